// File: rtl/c2_pkg.sv
// Shared types and constants for the C2 data-memory dump path.
package c2_pkg;

   localparam logic [7:0] FRAME_SOF_DEFAULT = 8'hDA;
   localparam int unsigned ADDR_BYTES = 4;
   localparam int unsigned CNT_BYTES  = 2;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SOF,
      ST_ADDR,
      ST_CNT,
      ST_RD,
      ST_WAIT,
      ST_DATA,
      ST_CHK,
      ST_END
   } dumper_state_e;

   // Words between two aligned addresses inclusive; an inverted range means nothing was written.
   function automatic logic [15:0] calc_words(input logic [31:0] lo,
                                              input logic [31:0] hi,
                                              input int unsigned max_words);
      logic [31:0] n;
      if (lo > hi) return 16'd0;
      n = ((hi - lo) >> 2) + 32'd1;
      if (n > max_words) n = max_words;
      return n[15:0];
   endfunction

endpackage

// File: rtl/c2_word_serializer.sv
// Holds one 32-bit word and hands it out as 4 bytes, least significant first, under valid/ready.
module c2_word_serializer
   import c2_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic [31:0] word_i,
   input  logic        ready_i,
   output logic [7:0]  byte_o,
   output logic        valid_o,
   output logic        last_o
);

   logic [31:0] word_reg;
   logic [1:0]  idx_reg;
   logic        active_reg;
   logic [7:0]  lanes [ADDR_BYTES];

   for (genvar gi = 0; gi < ADDR_BYTES; gi++) begin : g_lane
      assign lanes[gi] = word_reg[8*gi +: 8];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word_reg   <= '0;
         idx_reg    <= '0;
         active_reg <= 1'b0;
      end else if (load_i) begin
         word_reg   <= word_i;
         idx_reg    <= '0;
         active_reg <= 1'b1;
      end else if (active_reg && ready_i) begin
         idx_reg <= idx_reg + 2'd1;
         if (idx_reg == 2'd3) active_reg <= 1'b0;
      end
   end

   assign byte_o  = lanes[idx_reg];
   assign valid_o = active_reg;
   assign last_o  = active_reg && ready_i && (idx_reg == 2'd3);

endmodule

// File: rtl/c2_dmem_dumper.sv
// Streams data memory between the tracked min/max addresses as a framed byte stream to UART TX.
// Build option: define C2_DUMP_CHECKSUM_EN to append an XOR checksum byte after the payload.
module c2_dmem_dumper
   import c2_pkg::*;
#(
   parameter int unsigned MAX_WORDS = 1024,
   parameter logic [7:0]  FRAME_SOF = FRAME_SOF_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [31:0] min_addr_i,
   input  logic [31:0] max_addr_i,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_data_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        busy_o,
   output logic        done_o
);

`ifdef C2_DUMP_CHECKSUM_EN
   localparam dumper_state_e TAIL_STATE = ST_CHK;
`else
   localparam dumper_state_e TAIL_STATE = ST_END;
`endif

   dumper_state_e state_reg, state_next;
   logic [31:0]   addr_reg;
   logic [15:0]   cnt_reg;
   logic [15:0]   rem_reg;
   logic          cnt_sel_reg;
   logic          done_reg;
   logic          start_ok;
   logic          ser_load, ser_valid, ser_last;
   logic [31:0]   ser_word;
   logic [7:0]    ser_byte;
   logic [7:0]    tx_data;
   logic          tx_valid;

   // The done cycle is already IDLE, but a start there is still refused.
   assign start_ok = (state_reg == ST_IDLE) && start_i && !done_reg;

   c2_word_serializer u_ser (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (ser_load),
      .word_i  (ser_word),
      .ready_i (tx_ready_i),
      .byte_o  (ser_byte),
      .valid_o (ser_valid),
      .last_o  (ser_last)
   );

   always_comb begin
      state_next = state_reg;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      ser_load   = 1'b0;
      ser_word   = mem_data_i;
      case (state_reg)
         ST_IDLE: if (start_ok) state_next = ST_SOF;
         ST_SOF: begin
            tx_valid = 1'b1;
            tx_data  = FRAME_SOF;
            if (tx_ready_i) begin
               // addr_reg still equals lo here; it only advances between data words
               ser_load   = 1'b1;
               ser_word   = addr_reg;
               state_next = ST_ADDR;
            end
         end
         ST_ADDR: begin
            tx_valid = ser_valid;
            tx_data  = ser_byte;
            if (ser_last) state_next = ST_CNT;
         end
         ST_CNT: begin
            tx_valid = 1'b1;
            tx_data  = cnt_sel_reg ? cnt_reg[15:8] : cnt_reg[7:0];
            if (tx_ready_i && cnt_sel_reg)
               state_next = (cnt_reg == 16'd0) ? TAIL_STATE : ST_RD;
         end
         ST_RD:   state_next = ST_WAIT;
         ST_WAIT: begin
            ser_load   = 1'b1;
            state_next = ST_DATA;
         end
         ST_DATA: begin
            tx_valid = ser_valid;
            tx_data  = ser_byte;
            if (ser_last) state_next = (rem_reg == 16'd1) ? TAIL_STATE : ST_RD;
         end
`ifdef C2_DUMP_CHECKSUM_EN
         ST_CHK: begin
            tx_valid = 1'b1;
            tx_data  = chk_reg;
            if (tx_ready_i) state_next = ST_END;
         end
`endif
         ST_END:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg   <= ST_IDLE;
         addr_reg    <= '0;
         cnt_reg     <= '0;
         rem_reg     <= '0;
         cnt_sel_reg <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= (state_reg == ST_END);
         if (start_ok) begin
            addr_reg    <= min_addr_i & ~32'd3;
            cnt_reg     <= calc_words(min_addr_i & ~32'd3, max_addr_i & ~32'd3, MAX_WORDS);
            rem_reg     <= calc_words(min_addr_i & ~32'd3, max_addr_i & ~32'd3, MAX_WORDS);
            cnt_sel_reg <= 1'b0;
         end
         if (state_reg == ST_CNT && tx_ready_i) cnt_sel_reg <= ~cnt_sel_reg;
         if (state_reg == ST_DATA && ser_last) begin
            rem_reg <= rem_reg - 16'd1;
            if (rem_reg != 16'd1) addr_reg <= addr_reg + 32'd4;
         end
      end
   end

`ifdef C2_DUMP_CHECKSUM_EN
   logic [7:0] chk_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chk_reg <= '0;
      end else if (start_ok) begin
         chk_reg <= '0;
      end else if (tx_valid && tx_ready_i &&
                   (state_reg == ST_ADDR || state_reg == ST_CNT || state_reg == ST_DATA)) begin
         chk_reg <= chk_reg ^ tx_data;
      end
   end
`endif

   assign mem_addr_o = addr_reg;
   assign tx_data_o  = tx_data;
   assign tx_valid_o = tx_valid;
   assign busy_o     = (state_reg != ST_IDLE);
   assign done_o     = done_reg;

endmodule

// File: tb/tb_c2_dmem_dumper.sv
// Bench for c2_dmem_dumper: frame model from min/max + memory image, per-byte compare, literal pins.
module tb_c2_dmem_dumper;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] min_addr = '0;
   logic [31:0] max_addr = '0;
   logic [31:0] mem_addr;
   logic [31:0] mem_q = '0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        busy;
   logic        done;

   logic [31:0] mem [0:1023];
   logic [7:0]  exp_q [$];
   logic [7:0]  got_q [$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          acc_cnt = 0;
   bit          rnd_ready = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = '0;

`ifdef C2_DUMP_CHECKSUM_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic [7:0] lit1 [23] = '{8'hDA, 8'h10, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00,
                             8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                             8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h00, 8'hFF, 8'hEE, 8'hDD};
   logic [7:0] lit2 [7]  = '{8'hDA, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};

   c2_dmem_dumper dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .min_addr_i (min_addr),
      .max_addr_i (max_addr),
      .mem_addr_o (mem_addr),
      .mem_data_i (mem_q),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .tx_ready_i (tx_ready),
      .busy_o     (busy),
      .done_o     (done)
   );

   initial forever #5 clk = ~clk;

   // Synchronous-read data memory on port B
   always @(posedge clk) mem_q <= mem[mem_addr[11:2]];

   initial forever begin
      @(posedge clk);
      #1;
      tx_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected frame straight from the frame definition and the memory image
   task automatic build_expected(input logic [31:0] mn, input logic [31:0] mx);
      logic [31:0] lo, hi, a, w;
      int n;
      logic [7:0] x;
      lo = mn & ~32'd3;
      hi = mx & ~32'd3;
      if (lo > hi) n = 0;
      else if ((hi - lo) / 4 + 1 > 1024) n = 1024;
      else n = int'((hi - lo) / 4) + 1;
      exp_q.delete();
      exp_q.push_back(8'hDA);
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((lo >> (8 * k)) & 32'hFF));
      exp_q.push_back(8'(n % 256));
      exp_q.push_back(8'(n / 256));
      for (int i = 0; i < n; i++) begin
         a = lo + 32'(4 * i);
         w = mem[a[11:2]];
         for (int k = 0; k < 4; k++) exp_q.push_back(8'((w >> (8 * k)) & 32'hFF));
      end
      x = 8'h00;
      for (int i = 1; i < exp_q.size(); i++) x = x ^ exp_q[i];
      if (EXTRA == 1) exp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", {31'd0, tx_valid}, 32'd1);
            check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
         end
         if (tx_valid && tx_ready) begin
            got_q.push_back(tx_data);
            acc_cnt++;
            if (exp_q.size() == 0) check("extra_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            else check("frame_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   task automatic wait_done();
      int cyc = 0;
      while (!done && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic run_case(input logic [31:0] mn, input logic [31:0] mx,
                           input bit rnd, input bit start_at_done);
      build_expected(mn, mx);
      got_q.delete();
      rnd_ready = rnd;
      @(negedge clk);
      min_addr = mn;
      max_addr = mx;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_rise", {31'd0, busy}, 32'd1);
      @(negedge clk);
      start = 1'b1;
      min_addr = 32'h100;
      max_addr = 32'h200;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      check("frame_complete", exp_q.size(), 0);
      check("busy_at_done", {31'd0, busy}, 32'd0);
      if (start_at_done) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("start_at_done_ignored", {31'd0, busy}, 32'd0);
      end else begin
         @(negedge clk);
      end
      check("done_one_cycle", {31'd0, done}, 32'd0);
      rnd_ready = 1'b0;
      $display("dump min=%h max=%h bytes=%0d", mn, mx, got_q.size());
   endtask

   task automatic check_case1(input string tag);
      check({tag, "_len"}, got_q.size(), 23 + EXTRA);
      if (got_q.size() >= 23)
         for (int i = 0; i < 23; i++) check({tag, "_lit"}, {24'd0, got_q[i]}, {24'd0, lit1[i]});
      if (EXTRA == 1 && got_q.size() >= 24) check({tag, "_chk"}, {24'd0, got_q[23]}, 32'h14);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_5A5A;
      mem[4] = 32'h1122_3344;
      mem[5] = 32'h5566_7788;
      mem[6] = 32'h99AA_BBCC;
      mem[7] = 32'hDDEE_FF00;

      #12;
      check("rst_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_data", {24'd0, tx_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_case(32'h10, 32'h1C, 1'b0, 1'b1);
      check_case1("case1");

      run_case(32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
      check("case2_len", got_q.size(), 7 + EXTRA);
      if (got_q.size() >= 7)
         for (int i = 0; i < 7; i++) check("case2_lit", {24'd0, got_q[i]}, {24'd0, lit2[i]});

      run_case(32'h3, 32'h6, 1'b0, 1'b0);
      check("case3a_len", got_q.size(), 15 + EXTRA);
      if (got_q.size() >= 7) begin
         check("case3a_lo", {24'd0, got_q[1]}, 32'h00);
         check("case3a_n", {got_q[6], got_q[5]}, 32'h0002);
      end

      run_case(32'h0, 32'hFFFC, 1'b0, 1'b0);
      if (got_q.size() >= 7) check("case3b_n", {got_q[6], got_q[5]}, 32'h0400);
      check("case3b_len", got_q.size(), 7 + 4096 + EXTRA);

      run_case(32'h10, 32'h1C, 1'b1, 1'b0);
      check_case1("case4");

      // Abort mid-frame: reset lands between clock edges, outputs must clear at once
      build_expected(32'h10, 32'h1C);
      got_q.delete();
      @(negedge clk);
      min_addr = 32'h10;
      max_addr = 32'h1C;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 200 && got_q.size() < 9; c++) @(negedge clk);
      check("abort_reached_byte9", got_q.size(), 9);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid", {31'd0, tx_valid}, 32'd0);
      check("abort_data", {24'd0, tx_data}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_addr", mem_addr, 32'd0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_case(32'h10, 32'h1C, 1'b0, 1'b0);
      check_case1("case5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
